// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared ALU op, opcode/funct, state and mux-select encodings
package mc_ctrl_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_LUI = 3'd5;
  localparam logic [2:0] ALU_EQB = 3'd6;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [1:0] RD_RT = 2'd0;
  localparam logic [1:0] RD_RD = 2'd1;
  localparam logic [1:0] RD_RA = 2'd2;
  localparam logic [1:0] WD_ALUOUT = 2'd0;
  localparam logic [1:0] WD_MDR    = 2'd1;
  localparam logic [1:0] WD_PC     = 2'd2;
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;
  localparam logic [1:0] NPC_ALU    = 2'd0;
  localparam logic [1:0] NPC_ALUOUT = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    ALU_WB  = 4'd4,
    MEM_ADR = 4'd5,
    MEM_RD  = 4'd6,
    MEM_WB  = 4'd7,
    MEM_WR  = 4'd8,
    BRANCH  = 4'd9,
    JUMP    = 4'd10,
    JAL_WB  = 4'd11
  } state_t;
endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// mc_alu_dec: funct/opcode to aluop, extend mode and legality (jal legal only with MC_CTRL_JAL_EN)
module mc_alu_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] r_aluop,
  output logic       r_ill,
  output logic [2:0] i_aluop,
  output logic       i_ext,
  output logic       op_ill
);
  // R-type funct and I-type opcode decode, plus unsupported-opcode detection
  always_comb begin
    r_aluop = funct == FN_SUBU ? ALU_SUB :
              funct == FN_AND  ? ALU_AND :
              funct == FN_OR   ? ALU_OR  :
              funct == FN_SLT  ? ALU_SLT : ALU_ADD;
    r_ill   = !(funct inside {FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT});
    i_aluop = opcode == OP_ORI ? ALU_OR : opcode == OP_LUI ? ALU_LUI : ALU_ADD;
    i_ext   = opcode == OP_ADDIU;
`ifdef MC_CTRL_JAL_EN
    op_ill  = !(opcode inside {OP_RTYPE, OP_ORI, OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL});
`else
    op_ill  = !(opcode inside {OP_RTYPE, OP_ORI, OP_ADDIU, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_J});
`endif
  end
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control FSM; MC_CTRL_JAL_EN adds the JAL_WB state
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       mem_wr,
  output logic       rf_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_srca,
  output logic [1:0] alu_srcb,
  output logic       ext_op,
  output logic [1:0] npc_sel,
  output logic [2:0] aluop,
  output logic       illegal,
  output logic [3:0] state
);
  state_t     state_q, state_d;
  logic       rd_q, rd_d;
  logic [2:0] r_aluop, i_aluop;
  logic       r_ill, i_ext, op_ill;
  mc_alu_dec u_dec (
    .opcode (opcode),
    .funct  (funct),
    .r_aluop(r_aluop),
    .r_ill  (r_ill),
    .i_aluop(i_aluop),
    .i_ext  (i_ext),
    .op_ill (op_ill)
  );
  // state register and the rd/rt choice remembered from the execute class
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end
  assign state = reset ? 4'd0 : state_q;
  // next state and per-state outputs; everything stays 0 while reset is high
  always_comb begin
    state_d  = state_q;
    rd_d     = rd_q;
    pc_wr    = 1'b0;
    ir_wr    = 1'b0;
    mem_wr   = 1'b0;
    rf_wr    = 1'b0;
    reg_dst  = RD_RT;
    wd_sel   = WD_ALUOUT;
    alu_srca = 1'b0;
    alu_srcb = SRCB_RT;
    ext_op   = 1'b0;
    npc_sel  = NPC_ALU;
    aluop    = ALU_ADD;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          ir_wr    = 1'b1;
          pc_wr    = 1'b1;
          alu_srcb = SRCB_FOUR;
          state_d  = DECODE;
        end
        DECODE: begin
          alu_srcb = SRCB_IMM_SH;
          ext_op   = 1'b1;
          illegal  = op_ill;
          state_d  = op_ill ? FETCH :
                     opcode == OP_RTYPE ? EXE_R :
                     opcode inside {OP_ORI, OP_ADDIU, OP_LUI} ? EXE_I :
                     opcode inside {OP_LW, OP_SW} ? MEM_ADR :
                     opcode == OP_BEQ ? BRANCH :
`ifdef MC_CTRL_JAL_EN
                     opcode == OP_JAL ? JAL_WB :
`endif
                     JUMP;
        end
        EXE_R: begin
          alu_srca = 1'b1;
          aluop    = r_aluop;
          illegal  = r_ill;
          rd_d     = 1'b1;
          state_d  = r_ill ? FETCH : ALU_WB;
        end
        EXE_I: begin
          alu_srca = 1'b1;
          alu_srcb = SRCB_IMM;
          ext_op   = i_ext;
          aluop    = i_aluop;
          rd_d     = 1'b0;
          state_d  = ALU_WB;
        end
        ALU_WB: begin
          rf_wr   = 1'b1;
          reg_dst = rd_q ? RD_RD : RD_RT;
          state_d = FETCH;
        end
        MEM_ADR: begin
          alu_srca = 1'b1;
          alu_srcb = SRCB_IMM;
          ext_op   = 1'b1;
          state_d  = opcode == OP_SW ? MEM_WR : MEM_RD;
        end
        MEM_RD: state_d = MEM_WB;
        MEM_WB: begin
          rf_wr   = 1'b1;
          wd_sel  = WD_MDR;
          state_d = FETCH;
        end
        MEM_WR: begin
          mem_wr  = 1'b1;
          state_d = FETCH;
        end
        BRANCH: begin
          alu_srca = 1'b1;
          aluop    = ALU_SUB;
          npc_sel  = NPC_ALUOUT;
          pc_wr    = zero;
          state_d  = FETCH;
        end
        JUMP: begin
          pc_wr   = 1'b1;
          npc_sel = NPC_JUMP;
          state_d = FETCH;
        end
`ifdef MC_CTRL_JAL_EN
        JAL_WB: begin
          rf_wr   = 1'b1;
          reg_dst = RD_RA;
          wd_sel  = WD_PC;
          pc_wr   = 1'b1;
          npc_sel = NPC_JUMP;
          state_d = FETCH;
        end
`endif
        default: state_d = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: scoreboard bench for mc_ctrl; expected per-cycle outputs queued by the driver, checked by a monitor
module tb_mc_ctrl;
  typedef struct {
    string      name;
    logic [21:0] v;
  } exp_t;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       pc_wr, ir_wr, mem_wr, rf_wr, alu_srca, ext_op, illegal;
  logic [1:0] reg_dst, wd_sel, alu_srcb, npc_sel;
  logic [2:0] aluop;
  logic [3:0] state;
  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  mc_ctrl dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .mem_wr(mem_wr), .rf_wr(rf_wr),
    .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_srca(alu_srca), .alu_srcb(alu_srcb),
    .ext_op(ext_op), .npc_sel(npc_sel), .aluop(aluop), .illegal(illegal), .state(state)
  );
  always #5 clock = ~clock;
  function automatic logic [21:0] mk(int st, int pc, int ir, int mw, int rw, int rd, int wd,
                                     int sa, int sb, int ext, int npc, int alu, int ill);
    return {st[3:0], pc[0], ir[0], mw[0], rw[0], rd[1:0], wd[1:0], sa[0], sb[1:0], ext[0],
            npc[1:0], alu[2:0], ill[0]};
  endfunction
  wire [21:0] act = {state, pc_wr, ir_wr, mem_wr, rf_wr, reg_dst, wd_sel, alu_srca, alu_srcb,
                     ext_op, npc_sel, aluop, illegal};
  logic [21:0] E_RST, E_F, E_D, E_DILL, E_ALU_R, E_ALU_I, E_MADR, E_MRD, E_MWB, E_MWR, E_J, E_JAL;
  initial begin
    E_RST   = mk(0, 0,0,0,0, 0,0, 0,0,0, 0,0,0);
    E_F     = mk(0, 1,1,0,0, 0,0, 0,1,0, 0,0,0);
    E_D     = mk(1, 0,0,0,0, 0,0, 0,3,1, 0,0,0);
    E_DILL  = mk(1, 0,0,0,0, 0,0, 0,3,1, 0,0,1);
    E_ALU_R = mk(4, 0,0,0,1, 1,0, 0,0,0, 0,0,0);
    E_ALU_I = mk(4, 0,0,0,1, 0,0, 0,0,0, 0,0,0);
    E_MADR  = mk(5, 0,0,0,0, 0,0, 1,2,1, 0,0,0);
    E_MRD   = mk(6, 0,0,0,0, 0,0, 0,0,0, 0,0,0);
    E_MWB   = mk(7, 0,0,0,1, 0,1, 0,0,0, 0,0,0);
    E_MWR   = mk(8, 0,0,1,0, 0,0, 0,0,0, 0,0,0);
    E_J     = mk(10,1,0,0,0, 0,0, 0,0,0, 2,0,0);
    E_JAL   = mk(11,1,0,0,1, 2,2, 0,0,0, 2,0,0);
  end
  task automatic step(string name, logic [21:0] v);
    exp_t e;
    e.name = name;
    e.v = v;
    q.push_back(e);
    @(posedge clock);
    #1;
  endtask
  task automatic exe_r(logic [5:0] fn, int alu, string nm);
    opcode = 6'b000000;
    funct = fn;
    step({nm, "_fetch"}, E_F);
    step({nm, "_decode"}, E_D);
    step({nm, "_exe_r"}, mk(2, 0,0,0,0, 0,0, 1,0,0, 0,alu,0));
    step({nm, "_alu_wb"}, E_ALU_R);
  endtask
  task automatic exe_i(logic [5:0] op, int ext, int alu, string nm);
    opcode = op;
    step({nm, "_fetch"}, E_F);
    step({nm, "_decode"}, E_D);
    step({nm, "_exe_i"}, mk(3, 0,0,0,0, 0,0, 1,2,ext, 0,alu,0));
    step({nm, "_alu_wb"}, E_ALU_I);
  endtask
  task automatic beq(logic z, string nm);
    opcode = 6'b000100;
    zero = z;
    step({nm, "_fetch"}, E_F);
    step({nm, "_decode"}, E_D);
    step({nm, "_branch"}, mk(9, int'(z),0,0,0, 0,0, 1,0,0, 1,1,0));
  endtask
  // monitor: compare every presented cycle against the oldest queued expectation
  always @(negedge clock) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_chk++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL %s: got state=%0d pc=%b ir=%b mw=%b rw=%b rd=%0d wd=%0d sa=%b sb=%0d ext=%b npc=%0d alu=%0d ill=%b (vec %h), want vec %h",
                 e.name, state, pc_wr, ir_wr, mem_wr, rf_wr, reg_dst, wd_sel, alu_srca, alu_srcb,
                 ext_op, npc_sel, aluop, illegal, act, e.v);
      end
    end
  end
  initial begin
    @(posedge clock);
    #1;
    zero = 1'b1;
    step("reset0", E_RST);
    step("reset1", E_RST);
    reset = 1'b0;
    exe_r(6'b100011, 1, "subu");
    exe_r(6'b100100, 2, "and");
    exe_r(6'b101010, 4, "slt");
    opcode = 6'b100011;
    step("lw_fetch", E_F);
    step("lw_decode", E_D);
    step("lw_mem_adr", E_MADR);
    step("lw_mem_rd", E_MRD);
    step("lw_mem_wb", E_MWB);
    opcode = 6'b101011;
    step("sw_fetch", E_F);
    step("sw_decode", E_D);
    step("sw_mem_adr", E_MADR);
    step("sw_mem_wr", E_MWR);
    beq(1'b1, "beq_taken");
    beq(1'b0, "beq_not_taken");
    zero = 1'b1;
    exe_i(6'b001111, 0, 5, "lui");
    exe_i(6'b001101, 0, 3, "ori");
    exe_i(6'b001001, 1, 0, "addiu");
    opcode = 6'b000010;
    step("j_fetch", E_F);
    step("j_decode", E_D);
    step("j_jump", E_J);
    opcode = 6'b111111;
    step("ill_fetch", E_F);
    step("ill_decode", E_DILL);
    opcode = 6'b000011;
    step("jal_fetch", E_F);
`ifdef MC_CTRL_JAL_EN
    step("jal_decode", E_D);
    step("jal_wb", E_JAL);
`else
    step("jal_decode_ill", E_DILL);
`endif
    opcode = 6'b101011;
    step("rst_sw_fetch", E_F);
    step("rst_sw_decode", E_D);
    reset = 1'b1;
    step("rst_sw_mem_adr", E_RST);
    reset = 1'b0;
    step("rst_after_fetch", E_F);
    step("rst_after_decode", E_D);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clock);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control unit for the MIPS-subset CPU: the producing end of the ALU's `aluop`/`zero` interface. A Moore state machine sequences fetch, decode, execute, memory and writeback. Per state it drives the datapath enables, the mux selects and the 3-bit `aluop`. It samples the ALU's `zero` flag to resolve `beq`. It sits between the instruction register (opcode/funct) and the datapath (PC, IR, register file, memory, ALU).

## Interface
Parameters: none. Encodings come from the shared header.
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high
- `opcode`  in  6  IR[31:26], held stable by IR after FETCH
- `funct`  in  6  IR[5:0]
- `zero`  in  1  ALU zero flag, combinational in the same cycle
- `pc_wr`  out  1  PC load enable
- `ir_wr`  out  1  IR load enable
- `mem_wr`  out  1  data memory write
- `rf_wr`  out  1  register file write
- `reg_dst`  out  2  write address select: 0 = rt, 1 = rd, 2 = $31
- `wd_sel`  out  2  write data select: 0 = ALUOut, 1 = MDR, 2 = PC
- `alu_srca`  out  1  ALU A select: 0 = PC, 1 = rs
- `alu_srcb`  out  2  ALU B select: 0 = rt, 1 = 4, 2 = ext(imm), 3 = ext(imm)<<2
- `ext_op`  out  1  immediate extend: 0 = zero, 1 = sign
- `npc_sel`  out  2  next PC select: 0 = ALU result, 1 = ALUOut, 2 = {PC[31:28], IR[25:0], 2'b00}
- `aluop`  out  3  ALU operation: ADD=0, SUB=1, AND=2, OR=3, SLT=4, LUI=5, EQB=6
- `illegal`  out  1  one-cycle pulse in DECODE on an unsupported instruction
- `state`  out  4  current state, for debug

## Operation
- States: FETCH, DECODE, EXE_R, EXE_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JAL_WB.
- Any output not listed for a state is 0.
- FETCH: `ir_wr`=1, `pc_wr`=1, srca=0, srcb=1, ADD, npc_sel=0. Next state is DECODE.
- DECODE: srca=0, srcb=3, ext_op=1, ADD; this computes the branch target into ALUOut. Dispatch by opcode:
  - 000000 → EXE_R
  - 001101 ori, 001001 addiu, 001111 lui → EXE_I
  - 100011 lw, 101011 sw → MEM_ADR
  - 000100 beq → BRANCH
  - 000010 j → JUMP
  - 000011 jal → JAL_WB
  - anything else → FETCH, with `illegal`=1
- EXE_R: srca=1, srcb=0. `aluop` from funct: 100001 → ADD, 100011 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT. An unknown funct gives ADD and `illegal`=1. Next state is ALU_WB with reg_dst=1.
- EXE_I: srca=1, srcb=2.
  - ori: ext_op=0, OR
  - addiu: ext_op=1, ADD
  - lui: ext_op=0, LUI
  - Next state is ALU_WB with reg_dst=0.
- ALU_WB: `rf_wr`=1, wd_sel=0. reg_dst is held from the execute class (stored in a 1-bit register set in EXE_*). Next state is FETCH.
- MEM_ADR: srca=1, srcb=2, ext_op=1, ADD. Next state is MEM_RD for lw, MEM_WR for sw.
- MEM_RD → MEM_WB → FETCH. MEM_WB: `rf_wr`=1, reg_dst=0, wd_sel=1.
- MEM_WR: `mem_wr`=1. Next state is FETCH.
- BRANCH: srca=1, srcb=0, SUB, npc_sel=1, `pc_wr`=`zero`. This is the only Mealy output. Next state is FETCH.
- JUMP: `pc_wr`=1, npc_sel=2. Next state is FETCH.

## Timing
- Instruction length in cycles, counting FETCH:
  - beq, j: 3
  - R-type, I-type ALU, sw: 4
  - lw: 5
  - jal: 3
- `reset` high at a rising edge: the state register loads FETCH. While `reset` is high, all outputs are forced to 0.
  - This also holds for reset asserted mid-instruction; the instruction is abandoned with no partial write.
  - The first FETCH outputs appear in the cycle after `reset` falls.
- `illegal` is combinational from state + opcode/funct. No side effects: no write enable is asserted for an illegal instruction.
- Output glitches within a cycle are permitted. All consumers sample at the clock edge.

## Configuration
- `MC_CTRL_JAL_EN` defined: opcode 000011 enters JAL_WB, which asserts:
  - `rf_wr`=1, reg_dst=2, wd_sel=2, writing PC+4 (already in PC) to $31
  - `pc_wr`=1, npc_sel=2
  - Next state is FETCH.
- Undefined: JAL_WB does not exist, and 000011 is treated as illegal.

## Structure
- The shared header holds these defines so that ALU, controller and datapath agree:
  - `aluop` encodings (ADD..EQB)
  - opcode and funct constants
  - state encodings
  - mux-select constants for reg_dst, wd_sel, alu_srcb, npc_sel
- One sub-module, `mc_alu_dec`: the combinational funct/opcode → `aluop` and `illegal` decoder.

## Test plan
- Reset, then opcode 000000 with funct 100011 → states FETCH, DECODE, EXE_R, ALU_WB. `aluop`=1 in EXE_R; `rf_wr`=1 and reg_dst=1 in ALU_WB only.
- lw (100011) → 5 cycles. `aluop`=0 with srcb=2 in MEM_ADR; `rf_wr`=1 and wd_sel=1 in MEM_WB. `mem_wr` stays 0 throughout.
- beq (000100) with `zero`=1 → `pc_wr`=1 and npc_sel=1 in BRANCH. Repeated with `zero`=0 → `pc_wr`=0. Both cases return to FETCH.
- lui (001111) → `aluop`=5 and ext_op=0 in EXE_I; ori (001101) → `aluop`=3.
- opcode 111111 → `illegal`=1 for one cycle in DECODE, then FETCH, with no write enable ever asserted. With `MC_CTRL_JAL_EN` undefined, 000011 behaves the same way.
- `reset` asserted in MEM_WR's preceding cycle (MEM_ADR of sw) → `mem_wr` never goes to 1, and the state is FETCH after `reset` releases.
